// File: rtl/bus_arbiter_rr4_pkg.sv
// Shared definitions for the 4-way round-robin bus arbiter.
package bus_arbiter_rr4_pkg;
    localparam int N_REQ = 4;
    localparam int SEL_W = 2;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_e;
endpackage

// File: rtl/MUX32_4.sv
// 32-bit 4:1 data mux; select 0 picks data1_i.
module MUX32_4 (
    input  logic [1:0]  select_i,
    input  logic [31:0] data1_i,
    input  logic [31:0] data2_i,
    input  logic [31:0] data3_i,
    input  logic [31:0] data4_i,
    output logic [31:0] data_o
);
    // Plain select decode
    always_comb begin
        data_o = data1_i;
        unique case (select_i)
            2'd0: data_o = data1_i;
            2'd1: data_o = data2_i;
            2'd2: data_o = data3_i;
            2'd3: data_o = data4_i;
        endcase
    end
endmodule

// File: rtl/bus_arbiter_rr4.sv
// Round-robin arbiter sharing one 32-bit result path between 4 requesters.
// Grants are held for a whole burst (until last or the MAX_BURST cap) and the
// winning beat is captured in a single-entry valid/ready output register.
//
//   state    | meaning
//   ST_IDLE  | no grant; pick next winner starting at ptr
//   ST_GRANT | sel owns the path until last beat or burst cap
module bus_arbiter_rr4
    import bus_arbiter_rr4_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [N_REQ-1:0]        req_valid_i,
    input  logic [N_REQ*DATA_W-1:0] req_data_i,
    input  logic [N_REQ-1:0]        req_last_i,
    output logic [N_REQ-1:0]        req_ready_o,
    output logic                    out_valid_o,
    output logic [DATA_W-1:0]       out_data_o,
    output logic [SEL_W-1:0]        out_src_o,
    output logic                    out_last_o,
    input  logic                    out_ready_i,
    output logic                    busy_o
);
    localparam int CNT_W = $clog2(MAX_BURST);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

    state_e            state_q;
    logic [SEL_W-1:0]  ptr_q, sel_q;
    logic [CNT_W-1:0]  beat_cnt_q;
    logic              out_valid_q, out_last_q;
    logic [DATA_W-1:0] out_data_q;
    logic [SEL_W-1:0]  out_src_q;

    logic [SEL_W-1:0]  sel_d, ptr_d;
    logic [CNT_W-1:0]  beat_cnt_d;
    logic [DATA_W-1:0] mux_data;
    logic              out_free, xfer, burst_end;

    // First valid index at or after start, wrapping mod N_REQ
    function automatic logic [SEL_W-1:0] rr_pick(input logic [N_REQ-1:0] valid,
                                                 input logic [SEL_W-1:0] start);
        logic [SEL_W-1:0] pick;
        logic [SEL_W-1:0] idx;
        pick = start;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            idx = start + SEL_W'(i);
            if (valid[idx]) pick = idx;
        end
        return pick;
    endfunction

    MUX32_4 u_mux (
        .select_i (sel_q),
        .data1_i  (req_data_i[0*DATA_W +: DATA_W]),
        .data2_i  (req_data_i[1*DATA_W +: DATA_W]),
        .data3_i  (req_data_i[2*DATA_W +: DATA_W]),
        .data4_i  (req_data_i[3*DATA_W +: DATA_W]),
        .data_o   (mux_data)
    );

    assign out_free   = !out_valid_q | out_ready_i;
    assign xfer       = req_valid_i[sel_q] & req_ready_o[sel_q];
    assign burst_end  = req_last_i[sel_q] | (beat_cnt_q == CNT_LAST);
    assign sel_d      = rr_pick(req_valid_i, ptr_q);
    assign ptr_d      = sel_q + SEL_W'(1);
    assign beat_cnt_d = beat_cnt_q + CNT_W'(1);

    // Only the granted requester may see ready, and only when the output slot frees up
    always_comb begin
        req_ready_o = '0;
        if (state_q == ST_GRANT) req_ready_o[sel_q] = out_free;
    end

    // Arbitration FSM plus the single-entry output register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            sel_q       <= '0;
            beat_cnt_q  <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= '0;
            out_last_q  <= 1'b0;
        end else begin
            if (xfer) begin
                out_valid_q <= 1'b1;
                out_data_q  <= mux_data;
                out_src_q   <= sel_q;
                out_last_q  <= req_last_i[sel_q];
            end else if (out_valid_q && out_ready_i) begin
                out_valid_q <= 1'b0;
            end

            unique case (state_q)
                ST_IDLE: begin
                    if (|req_valid_i) begin
                        sel_q      <= sel_d;
                        beat_cnt_q <= '0;
                        state_q    <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    if (xfer) begin
                        if (burst_end) begin
                            // counter is cleared rather than incremented so it never wraps
                            beat_cnt_q <= '0;
                            ptr_q      <= ptr_d;
                            state_q    <= ST_IDLE;
                        end else begin
                            beat_cnt_q <= beat_cnt_d;
                        end
                    end
                end
            endcase
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign out_src_o   = out_src_q;
    assign out_last_o  = out_last_q;
    assign busy_o      = (state_q == ST_GRANT);
endmodule

// File: tb/tb_bus_arbiter_rr4.sv
// Scoreboard bench for bus_arbiter_rr4: per-requester source queues feed the
// DUT, expected output beats are queued by each test and popped on handshake.
module tb_bus_arbiter_rr4;
    logic         clk_i = 1'b0;
    logic         rst_i;
    logic [3:0]   req_valid_i;
    logic [127:0] req_data_i;
    logic [3:0]   req_last_i;
    logic [3:0]   req_ready_o;
    logic         out_valid_o;
    logic [31:0]  out_data_o;
    logic [1:0]   out_src_o;
    logic         out_last_o;
    logic         out_ready_i;
    logic         busy_o;

    bus_arbiter_rr4 dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .req_valid_i (req_valid_i),
        .req_data_i  (req_data_i),
        .req_last_i  (req_last_i),
        .req_ready_o (req_ready_o),
        .out_valid_o (out_valid_o),
        .out_data_o  (out_data_o),
        .out_src_o   (out_src_o),
        .out_last_o  (out_last_o),
        .out_ready_i (out_ready_i),
        .busy_o      (busy_o)
    );

    always #5 clk_i = ~clk_i;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int pop_cnt  = 0;
    bit mon_en   = 1'b0;

    logic [32:0] srcq [4][$];   // {last, data}
    logic [34:0] expq [$];      // {src, last, data}
    int          pop_cyc [$];
    logic [3:0]  acc  = '0;
    logic [3:0]  hold = '0;

    function automatic logic [34:0] mk(input logic [1:0] src, input logic last,
                                       input logic [31:0] data);
        return {src, last, data};
    endfunction

    always @(posedge clk_i) cyc++;

    // Negedge: record accepted beats and score consumed output beats
    always @(negedge clk_i) begin
        logic [34:0] e;
        acc = req_valid_i & req_ready_o;
        if (mon_en && !rst_i && out_valid_o && out_ready_i) begin
            checks++;
            if (expq.size() == 0) begin
                failures++;
                $display("FAIL unexpected_beat: got src=%0d last=%0b data=%h, required no beat",
                         out_src_o, out_last_o, out_data_o);
            end else begin
                e = expq.pop_front();
                if ({out_src_o, out_last_o, out_data_o} !== e) begin
                    failures++;
                    $display("FAIL beat: got src=%0d last=%0b data=%h, required src=%0d last=%0b data=%h",
                             out_src_o, out_last_o, out_data_o, e[34:33], e[32], e[31:0]);
                end
            end
            pop_cyc.push_back(cyc);
            pop_cnt++;
        end
    end

    // Requester drivers: retire accepted beats, present the next one
    always @(posedge clk_i) begin
        logic [32:0] b;
        #1;
        for (int k = 0; k < 4; k++) begin
            if (acc[k] && srcq[k].size() > 0) void'(srcq[k].pop_front());
            if (srcq[k].size() > 0 && !hold[k]) begin
                b = srcq[k][0];
                req_valid_i[k]         = 1'b1;
                req_data_i[32*k +: 32] = b[31:0];
                req_last_i[k]          = b[32];
            end else begin
                req_valid_i[k]         = 1'b0;
                req_data_i[32*k +: 32] = '0;
                req_last_i[k]          = 1'b0;
            end
        end
        acc = '0;
    end

    task automatic tick();
        @(posedge clk_i);
        #2;
    endtask

    task automatic wait_drain(input int limit, output bit ok);
        int n;
        n = 0;
        while (expq.size() > 0 && n < limit) begin
            @(posedge clk_i);
            n++;
        end
        ok = (expq.size() == 0);
        tick();
        tick();
    endtask

    task automatic wait_pops(input int cnt, input int limit, output bit ok);
        int base, n;
        base = pop_cnt;
        n = 0;
        while (pop_cnt < base + cnt && n < limit) begin
            tick();
            n++;
        end
        ok = (pop_cnt >= base + cnt);
    endtask

    task automatic do_reset();
        mon_en = 1'b0;
        tick();
        rst_i = 1'b1;
        for (int k = 0; k < 4; k++) srcq[k].delete();
        expq.delete();
        pop_cyc.delete();
        hold = '0;
        out_ready_i = 1'b1;
        tick();
        tick();
        rst_i = 1'b0;
        mon_en = 1'b1;
    endtask

    task automatic test_reset();
        bit ok;
        repeat (3) tick();
        checks++;
        if ({out_valid_o, out_data_o, out_src_o, out_last_o, req_ready_o, busy_o} !== '0) begin
            failures++;
            $display("FAIL reset_state: got valid=%0b data=%h src=%0d last=%0b ready=%b busy=%0b, required all 0",
                     out_valid_o, out_data_o, out_src_o, out_last_o, req_ready_o, busy_o);
        end
        rst_i = 1'b0;
        mon_en = 1'b0;
        for (int i = 0; i < 6; i++) srcq[0].push_back({1'b0, 32'h100 + 32'(i)});
        srcq[0][5][32] = 1'b1;
        repeat (4) tick();
        checks++;
        if (out_valid_o !== 1'b1 || busy_o !== 1'b1) begin
            failures++;
            $display("FAIL reset_preburst: got valid=%0b busy=%0b, required 1 1", out_valid_o, busy_o);
        end
        rst_i = 1'b1;
        #1;
        checks++;
        if ({out_valid_o, out_data_o, out_src_o, out_last_o} !== '0) begin
            failures++;
            $display("FAIL reset_mid_out: got valid=%0b data=%h src=%0d last=%0b, required 0",
                     out_valid_o, out_data_o, out_src_o, out_last_o);
        end
        checks++;
        if (req_ready_o !== 4'b0 || busy_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_ctl: got ready=%b busy=%0b, required 0000 0", req_ready_o, busy_o);
        end
        for (int k = 0; k < 4; k++) srcq[k].delete();
        tick();
        tick();
        rst_i = 1'b0;
        mon_en = 1'b1;
        srcq[2].push_back({1'b1, 32'hC2});
        expq.push_back(mk(2'd2, 1'b1, 32'hC2));
        wait_drain(50, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL reset_after_drain: got %0d beats left, required 0", expq.size());
        end
    endtask

    task automatic test_fairness();
        bit ok;
        do_reset();
        srcq[0].push_back({1'b1, 32'h10});
        srcq[0].push_back({1'b1, 32'h11});
        srcq[1].push_back({1'b1, 32'h20});
        srcq[2].push_back({1'b1, 32'h30});
        srcq[3].push_back({1'b1, 32'h40});
        expq.push_back(mk(2'd0, 1'b1, 32'h10));
        expq.push_back(mk(2'd1, 1'b1, 32'h20));
        expq.push_back(mk(2'd2, 1'b1, 32'h30));
        expq.push_back(mk(2'd3, 1'b1, 32'h40));
        expq.push_back(mk(2'd0, 1'b1, 32'h11));
        wait_drain(100, ok);
        checks++;
        if (!ok || pop_cyc.size() != 5) begin
            failures++;
            $display("FAIL fair_drain: got %0d beats popped, required 5", pop_cyc.size());
        end else begin
            for (int i = 1; i < 5; i++) begin
                checks++;
                if (pop_cyc[i] - pop_cyc[i-1] != 2) begin
                    failures++;
                    $display("FAIL fair_spacing: got gap %0d at beat %0d, required 2",
                             pop_cyc[i] - pop_cyc[i-1], i);
                end
            end
        end
    endtask

    task automatic test_burst();
        bit ok;
        do_reset();
        srcq[1].push_back({1'b0, 32'hA1});
        srcq[1].push_back({1'b0, 32'hA2});
        srcq[1].push_back({1'b1, 32'hA3});
        tick();
        srcq[0].push_back({1'b1, 32'hB0});
        expq.push_back(mk(2'd1, 1'b0, 32'hA1));
        expq.push_back(mk(2'd1, 1'b0, 32'hA2));
        expq.push_back(mk(2'd1, 1'b1, 32'hA3));
        expq.push_back(mk(2'd0, 1'b1, 32'hB0));
        wait_drain(100, ok);
        checks++;
        if (!ok || pop_cyc.size() != 4) begin
            failures++;
            $display("FAIL burst_drain: got %0d beats popped, required 4", pop_cyc.size());
        end else begin
            checks++;
            if (pop_cyc[1] - pop_cyc[0] != 1 || pop_cyc[2] - pop_cyc[1] != 1) begin
                failures++;
                $display("FAIL burst_contiguous: got gaps %0d %0d, required 1 1",
                         pop_cyc[1] - pop_cyc[0], pop_cyc[2] - pop_cyc[1]);
            end
        end
    endtask

    task automatic test_cap();
        bit ok;
        do_reset();
        for (int i = 0; i < 20; i++)
            srcq[3].push_back({(i == 19) ? 1'b1 : 1'b0, 32'h300 + 32'(i)});
        tick();
        srcq[0].push_back({1'b1, 32'hB4});
        for (int i = 0; i < 16; i++) expq.push_back(mk(2'd3, 1'b0, 32'h300 + 32'(i)));
        expq.push_back(mk(2'd0, 1'b1, 32'hB4));
        for (int i = 16; i < 20; i++)
            expq.push_back(mk(2'd3, (i == 19) ? 1'b1 : 1'b0, 32'h300 + 32'(i)));
        wait_drain(300, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL cap_drain: got %0d beats left, required 0", expq.size());
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        logic [31:0] held;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            srcq[1].push_back({(i == 7) ? 1'b1 : 1'b0, 32'h500 + 32'(i)});
            expq.push_back(mk(2'd1, (i == 7) ? 1'b1 : 1'b0, 32'h500 + 32'(i)));
        end
        wait_pops(2, 50, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL bp_start: got %0d beats popped, required 2", pop_cnt);
        end
        out_ready_i = 1'b0;
        held = '0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            if (i == 0) held = out_data_o;
            checks++;
            if (req_ready_o !== 4'b0 || out_valid_o !== 1'b1 || out_data_o !== held) begin
                failures++;
                $display("FAIL bp_stall: got ready=%b valid=%0b data=%h, required 0000 1 %h",
                         req_ready_o, out_valid_o, out_data_o, held);
            end
        end
        tick();
        out_ready_i = 1'b1;
        wait_drain(100, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL bp_drain: got %0d beats left, required 0", expq.size());
        end
    endtask

    task automatic test_stall();
        bit ok;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            srcq[2].push_back({(i == 5) ? 1'b1 : 1'b0, 32'h600 + 32'(i)});
            expq.push_back(mk(2'd2, (i == 5) ? 1'b1 : 1'b0, 32'h600 + 32'(i)));
        end
        tick();
        srcq[0].push_back({1'b1, 32'hB6});
        expq.push_back(mk(2'd0, 1'b1, 32'hB6));
        wait_pops(2, 50, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL stall_start: got %0d beats popped, required 2", pop_cnt);
        end
        hold[2] = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            checks++;
            if (busy_o !== 1'b1 || req_ready_o !== 4'b0100 || req_valid_i[2] !== 1'b0) begin
                failures++;
                $display("FAIL stall_hold: got busy=%0b ready=%b valid2=%0b, required 1 0100 0",
                         busy_o, req_ready_o, req_valid_i[2]);
            end
        end
        hold[2] = 1'b0;
        wait_drain(100, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL stall_drain: got %0d beats left, required 0", expq.size());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish by 200000, required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_i       = 1'b1;
        out_ready_i = 1'b1;
        req_valid_i = '0;
        req_data_i  = '0;
        req_last_i  = '0;
        test_reset();
        test_fairness();
        test_burst();
        test_cap();
        test_backpressure();
        test_stall();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
